// File: rtl/mul_hash_reduce_if.sv
// mul_hash_reduce_if: beat bus from the multiplier stage into mul_hash_reduce
// and the hash result back out.
//   s_valid/s_first/s_last/s_half/s_inv : beat tags
//   ab*/ab*_1sc        : 32-bit chunk x b_j terms (plain / complemented chunk)
//   msk_ab*/msk_ab*_1sc: 24-bit byte x b_j terms for a one-byte final chunk
//   hash_valid/hash/hash_len/err : result side
// The master modport is the producer side; the slave modport is the reducer.
interface mul_hash_reduce_if #(
  parameter int HASH_W = 13
);
  logic              s_valid, s_first, s_last, s_half, s_inv;
  logic [31:0]       ab0, ab1, ab2, ab3;
  logic [31:0]       ab0_1sc, ab1_1sc, ab2_1sc, ab3_1sc;
  logic [23:0]       msk_ab0, msk_ab1, msk_ab2, msk_ab3;
  logic [23:0]       msk_ab0_1sc, msk_ab1_1sc, msk_ab2_1sc, msk_ab3_1sc;
  logic              hash_valid;
  logic [HASH_W-1:0] hash;
  logic [3:0]        hash_len;
  logic              err;

  modport master (
    output s_valid, s_first, s_last, s_half, s_inv,
    output ab0, ab1, ab2, ab3, ab0_1sc, ab1_1sc, ab2_1sc, ab3_1sc,
    output msk_ab0, msk_ab1, msk_ab2, msk_ab3,
    output msk_ab0_1sc, msk_ab1_1sc, msk_ab2_1sc, msk_ab3_1sc,
    input  hash_valid, hash, hash_len, err
  );

  modport slave (
    input  s_valid, s_first, s_last, s_half, s_inv,
    input  ab0, ab1, ab2, ab3, ab0_1sc, ab1_1sc, ab2_1sc, ab3_1sc,
    input  msk_ab0, msk_ab1, msk_ab2, msk_ab3,
    input  msk_ab0_1sc, msk_ab1_1sc, msk_ab2_1sc, msk_ab3_1sc,
    output hash_valid, hash, hash_len, err
  );
endinterface

// File: rtl/mul_hash_reduce.sv
// mul_hash_reduce: accumulates per-chunk partial products into
// key * 64'h0b4e0ef37bc32127 (mod 2^64) and emits the top HASH_W bits.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mul_hash_reduce_if.slave (beat in, hash/hash_len/err out)
// Pipeline: stage A registers four shifted partials, stage B adds them into
// the accumulator and publishes the hash on the last chunk of a key.

// One term lane: pick the term variant and place it at weight 2^(16(idx+J)).
module mul_hash_reduce_term #(
  parameter int J = 0
) (
  input  logic [31:0] ab,
  input  logic [31:0] ab_1sc,
  input  logic [23:0] msk,
  input  logic [23:0] msk_1sc,
  input  logic        half,
  input  logic        inv,
  input  logic [1:0]  idx,
  output logic [63:0] part
);
  logic [31:0] sel;
  logic [2:0]  w;

  always_comb begin
    if (half) sel = inv ? {8'b0, msk_1sc} : {8'b0, msk};
    else      sel = inv ? ab_1sc : ab;
    w = {1'b0, idx} + 3'(J);
    // Weights of 2^64 and above vanish modulo 2^64.
    if (w > 3'd3) part = '0;
    else          part = {32'b0, sel} << {w, 4'b0000};
  end
endmodule

module mul_hash_reduce #(
  parameter int HASH_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  mul_hash_reduce_if.slave  bus
);
  localparam int NUM_TERMS = 4;

  typedef enum logic {IDLE, ACC} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       inv_q, inv_d;
  logic       err_q, err_d;

  // Beat decode
  logic       take;       // beat joins the accumulation
  logic [1:0] idx;        // chunk index of the accepted beat
  logic       inv_eff;    // first beat uses its own s_inv, later beats the latch

  logic [NUM_TERMS-1:0][31:0] ab_a, ab1_a;
  logic [NUM_TERMS-1:0][23:0] msk_a, msk1_a;
  logic [NUM_TERMS-1:0][63:0] part_d, part_q;

  logic       a_vld_q, a_first_q, a_last_q;
  logic [3:0] a_len_q, a_len_d;

  logic [63:0]       acc_q, acc_d, sum;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [3:0]        len_q, len_d;
  logic              hv_q, hv_d;

  assign ab_a   = {bus.ab3, bus.ab2, bus.ab1, bus.ab0};
  assign ab1_a  = {bus.ab3_1sc, bus.ab2_1sc, bus.ab1_1sc, bus.ab0_1sc};
  assign msk_a  = {bus.msk_ab3, bus.msk_ab2, bus.msk_ab1, bus.msk_ab0};
  assign msk1_a = {bus.msk_ab3_1sc, bus.msk_ab2_1sc, bus.msk_ab1_1sc, bus.msk_ab0_1sc};

  // Protocol FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    err_d   = 1'b0;
    take    = 1'b0;
    idx     = cnt_q[1:0];
    inv_eff = inv_q;
    if (bus.s_valid) begin
      if (bus.s_first) begin
        // A first beat inside a key abandons that key and restarts.
        err_d   = (state_q == ACC);
        inv_d   = bus.s_inv;
        inv_eff = bus.s_inv;
        idx     = 2'd0;
        if (bus.s_half && !bus.s_last) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          take    = 1'b1;
          state_d = bus.s_last ? IDLE : ACC;
          cnt_d   = bus.s_last ? 3'd0 : 3'd1;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (cnt_q == 3'd4 || (bus.s_half && !bus.s_last)) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = 3'd0;
      end else begin
        take    = 1'b1;
        state_d = bus.s_last ? IDLE : ACC;
        cnt_d   = bus.s_last ? 3'd0 : cnt_q + 3'd1;
      end
    end
  end

  // Stage A term lanes
  for (genvar j = 0; j < NUM_TERMS; j++) begin : g_term
    mul_hash_reduce_term #(.J(j)) u_term (
      .ab      (ab_a[j]),
      .ab_1sc  (ab1_a[j]),
      .msk     (msk_a[j]),
      .msk_1sc (msk1_a[j]),
      .half    (bus.s_half),
      .inv     (inv_eff),
      .idx     (idx),
      .part    (part_d[j])
    );
  end

  // Bytes so far = 2 per chunk, minus one for a half final chunk.
  assign a_len_d = {1'b0, idx, 1'b0} + 4'd2 - {3'b0, bus.s_half};

  // Stage B
  always_comb begin
    sum = '0;
    for (int j = 0; j < NUM_TERMS; j++) sum = sum + part_q[j];
    acc_d  = acc_q;
    hash_d = hash_q;
    len_d  = len_q;
    hv_d   = 1'b0;
    if (a_vld_q) begin
      acc_d = (a_first_q ? 64'd0 : acc_q) + sum;
      if (a_last_q) begin
        hash_d = acc_d[63 -: HASH_W];
        len_d  = a_len_q;
        hv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      inv_q     <= 1'b0;
      err_q     <= 1'b0;
      a_vld_q   <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_len_q   <= 4'd0;
      part_q    <= '0;
      acc_q     <= 64'd0;
      hash_q    <= '0;
      len_q     <= 4'd0;
      hv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inv_q     <= inv_d;
      err_q     <= err_d;
      a_vld_q   <= take;
      a_first_q <= bus.s_first;
      a_last_q  <= bus.s_last;
      a_len_q   <= a_len_d;
      part_q    <= part_d;
      acc_q     <= acc_d;
      hash_q    <= hash_d;
      len_q     <= len_d;
      hv_q      <= hv_d;
    end
  end

  assign bus.hash_valid = hv_q;
  assign bus.hash       = hash_q;
  assign bus.hash_len   = len_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_mul_hash_reduce.sv
// tb_mul_hash_reduce: directed vectors for mul_hash_reduce. Expected outputs
// come from a key-level model (key value * B mod 2^64) indexed by clock edge;
// literal pins check the model on the hand-computed cases.
module tb_mul_hash_reduce;
  localparam int HW = 13;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_hash_reduce_if #(.HASH_W(HW)) bus ();
  mul_hash_reduce #(.HASH_W(HW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] bconst = 64'h0b4e0ef37bc32127;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int hv_cnt = 0;
  int last_e = 0;
  bit chk_en = 1'b0;

  bit          exp_hv  [0:DEPTH-1];
  bit          exp_err [0:DEPTH-1];
  logic [HW-1:0] exp_hash [0:DEPTH-1];
  logic [3:0]  exp_len [0:DEPTH-1];

  // Key-level model state
  bit          m_active = 1'b0;
  int          m_n = 0;
  logic [63:0] m_key = '0;
  bit          m_inv = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, expv);
    end
  endtask

  // Compare process: outputs after edge n are checked against the model at n.
  always @(negedge clk) begin
    if (bus.hash_valid === 1'b1) hv_cnt++;
    if (chk_en) begin
      chk("hash_valid", 64'(bus.hash_valid), 64'(exp_hv[edge_n]));
      chk("err", 64'(bus.err), 64'(exp_err[edge_n]));
      if (exp_hv[edge_n]) begin
        chk("hash", 64'(bus.hash), 64'(exp_hash[edge_n]));
        chk("hash_len", 64'(bus.hash_len), 64'(exp_len[edge_n]));
      end
    end
  end

  function automatic logic [31:0] t32(input logic [15:0] x, input logic [15:0] b);
    return {16'b0, x} * {16'b0, b};
  endfunction
  function automatic logic [23:0] t24(input logic [7:0] x, input logic [15:0] b);
    return {16'b0, x} * {8'b0, b};
  endfunction

  // Protocol rules at key level; e is the edge that samples the beat.
  task automatic model(input int e, input bit f, input bit l, input bit h,
                       input bit i, input logic [15:0] c);
    logic [63:0] v, prod;
    logic [7:0]  bt;
    if (!f) begin
      if (!m_active) begin exp_err[e] = 1'b1; return; end
      if (m_n == 4) begin exp_err[e] = 1'b1; m_active = 1'b0; return; end
    end else begin
      if (m_active) exp_err[e] = 1'b1;
      m_active = 1'b1; m_n = 0; m_key = '0; m_inv = i;
    end
    if (h && !l) begin exp_err[e] = 1'b1; m_active = 1'b0; return; end
    if (h) begin
      bt = m_inv ? ~c[7:0] : c[7:0];
      v = {56'b0, bt};
    end else begin
      v = {48'b0, (m_inv ? ~c : c)};
    end
    m_key = m_key | (v << (16 * m_n));
    m_n++;
    if (l) begin
      prod = m_key * bconst;
      exp_hv[e+1]   = 1'b1;
      exp_hash[e+1] = prod[63 -: HW];
      exp_len[e+1]  = 4'(2 * m_n - (h ? 1 : 0));
      m_active = 1'b0;
    end
  endtask

  task automatic beat(input bit f, input bit l, input bit h, input bit i, input logic [15:0] c);
    logic [15:0] nc;
    logic [7:0]  by, nb;
    @(negedge clk);
    nc = ~c; by = c[7:0]; nb = ~c[7:0];
    bus.s_valid = 1'b1; bus.s_first = f; bus.s_last = l; bus.s_half = h; bus.s_inv = i;
    bus.ab0 = t32(c, bconst[15:0]);   bus.ab1 = t32(c, bconst[31:16]);
    bus.ab2 = t32(c, bconst[47:32]);  bus.ab3 = t32(c, bconst[63:48]);
    bus.ab0_1sc = t32(nc, bconst[15:0]);  bus.ab1_1sc = t32(nc, bconst[31:16]);
    bus.ab2_1sc = t32(nc, bconst[47:32]); bus.ab3_1sc = t32(nc, bconst[63:48]);
    bus.msk_ab0 = t24(by, bconst[15:0]);  bus.msk_ab1 = t24(by, bconst[31:16]);
    bus.msk_ab2 = t24(by, bconst[47:32]); bus.msk_ab3 = t24(by, bconst[63:48]);
    bus.msk_ab0_1sc = t24(nb, bconst[15:0]);  bus.msk_ab1_1sc = t24(nb, bconst[31:16]);
    bus.msk_ab2_1sc = t24(nb, bconst[47:32]); bus.msk_ab3_1sc = t24(nb, bconst[63:48]);
    last_e = edge_n + 1;
    model(last_e, f, l, h, i, c);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid = 1'b0; bus.s_first = 1'b0; bus.s_last = 1'b0; bus.s_half = 1'b0;
    end
  endtask

  // Pin the model's prediction for the most recent last beat to a literal.
  task automatic pin(input string nm, input logic [HW-1:0] h, input logic [3:0] l);
    chk({nm, "_model_hv"}, 64'(exp_hv[last_e+1]), 64'd1);
    chk({nm, "_model_hash"}, 64'(exp_hash[last_e+1]), 64'(h));
    chk({nm, "_model_len"}, 64'(exp_len[last_e+1]), 64'(l));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_hv[edge_n+k] = 1'b0; exp_err[edge_n+k] = 1'b0;
    end
    m_active = 1'b0;
    repeat (n - 1) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_hv[k] = 1'b0; exp_err[k] = 1'b0; exp_hash[k] = '0; exp_len[k] = '0;
    end
    bus.s_valid = 1'b0; bus.s_first = 1'b0; bus.s_last = 1'b0;
    bus.s_half = 1'b0; bus.s_inv = 1'b0;
    bus.ab0 = '0; bus.ab1 = '0; bus.ab2 = '0; bus.ab3 = '0;
    bus.ab0_1sc = '0; bus.ab1_1sc = '0; bus.ab2_1sc = '0; bus.ab3_1sc = '0;
    bus.msk_ab0 = '0; bus.msk_ab1 = '0; bus.msk_ab2 = '0; bus.msk_ab3 = '0;
    bus.msk_ab0_1sc = '0; bus.msk_ab1_1sc = '0; bus.msk_ab2_1sc = '0; bus.msk_ab3_1sc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hash_valid", 64'(bus.hash_valid), 64'd0);
    chk("rst_hash", 64'(bus.hash), 64'd0);
    chk("rst_hash_len", 64'(bus.hash_len), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single full beat, chunk 1 -> product B
    beat(1, 1, 0, 0, 16'h0001); pin("t1", 13'h169, 4'd2);
    gap(3);
    // Zero chunk with inversion -> 0xFFFF * B
    beat(1, 1, 0, 1, 16'h0000); pin("t2", 13'h074, 4'd2);
    gap(3);
    // Half chunk, byte 1 -> product B, one byte
    beat(1, 1, 1, 0, 16'h0001); pin("t3", 13'h169, 4'd1);
    gap(3);
    // Two chunks back-to-back -> B << 16
    beat(1, 0, 0, 0, 16'h0000);
    beat(0, 1, 0, 0, 16'h0001); pin("t4", 13'h1DE, 4'd4);
    gap(3);
    // Same key with a 3-cycle gap between chunks
    beat(1, 0, 0, 0, 16'h0000);
    gap(3);
    beat(0, 1, 0, 0, 16'h0001); pin("t4gap", 13'h1DE, 4'd4);
    gap(3);

    // Overlong key: 5th beat errors, then a stray non-first beat errors
    beat(1, 0, 0, 0, 16'h1111);
    beat(0, 0, 0, 0, 16'h2222);
    beat(0, 0, 0, 0, 16'h3333);
    beat(0, 0, 0, 0, 16'h4444);
    beat(0, 0, 0, 0, 16'h5555);
    chk("t5_model_err5", 64'(exp_err[last_e]), 64'd1);
    beat(0, 1, 0, 0, 16'h6666);
    chk("t5_model_err6", 64'(exp_err[last_e]), 64'd1);
    beat(1, 1, 0, 0, 16'h0001); pin("t5new", 13'h169, 4'd2);
    gap(3);

    // Abandoned key followed by a fresh first+last beat
    beat(1, 0, 0, 0, 16'h1111);
    beat(1, 1, 0, 0, 16'h0001); pin("t6", 13'h169, 4'd2);
    gap(3);
    // Half without last is discarded, then stray continuation errors
    beat(1, 0, 1, 0, 16'h00AB);
    beat(0, 1, 0, 0, 16'h0001);
    gap(3);

    // Full 4-chunk inverted key with a half final chunk (weights past 2^64 drop)
    beat(1, 0, 0, 1, 16'hA5A5);
    beat(0, 0, 0, 0, 16'h1234);
    beat(0, 0, 0, 1, 16'hFEDC);
    beat(0, 1, 1, 0, 16'h0077);
    gap(3);
    // Full 4-chunk plain key
    beat(1, 0, 0, 0, 16'hDEAD);
    beat(0, 0, 0, 0, 16'hBEEF);
    beat(0, 0, 0, 0, 16'hCAFE);
    beat(0, 1, 0, 0, 16'hF00D);
    gap(3);

    // Reset mid-key, then a fresh key -> 2B
    beat(1, 0, 0, 0, 16'h1234);
    beat(0, 0, 0, 0, 16'h5678);
    do_reset(3);
    gap(1);
    beat(1, 1, 0, 0, 16'h0002); pin("t7", 13'h2D3, 4'd2);
    gap(3);

    // 16 back-to-back single-beat keys
    c0 = hv_cnt;
    for (int k = 0; k < 16; k++)
      beat(1, 1, k[0] & k[2], k[1], 16'(k * 16'h1357 + 16'h0101));
    gap(4);
    chk("burst_count", 64'(hv_cnt - c0), 64'd16);

    gap(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: got running expected done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
